// File: rtl/graha_pkg.sv
// Shared constants, types and arithmetic helpers for the graha VDD sequencer.
package graha_pkg;

  localparam int NUM_DOMAINS = 9;

  // Domain indices, core first, always-on/backup last.
  localparam logic [3:0] SURYA   = 4'd0;
  localparam logic [3:0] CHANDRA = 4'd1;
  localparam logic [3:0] MANGALA = 4'd2;
  localparam logic [3:0] BUDHA   = 4'd3;
  localparam logic [3:0] GURU    = 4'd4;
  localparam logic [3:0] SHUKRA  = 4'd5;
  localparam logic [3:0] SHANI   = 4'd6;
  localparam logic [3:0] RAHU    = 4'd7;
  localparam logic [3:0] KETU    = 4'd8;
  localparam logic [3:0] IDX_NONE = 4'hF;

  // Regulator codes on the 8-bit scale (255 = 3.3V).
  localparam logic [7:0] V_0_4V = 8'd31;
  localparam logic [7:0] V_0_6V = 8'd46;
  localparam logic [7:0] V_0_7V = 8'd54;
  localparam logic [7:0] V_0_8V = 8'd62;
  localparam logic [7:0] V_1_0V = 8'd77;
  localparam logic [7:0] V_1_2V = 8'd93;
  localparam logic [7:0] V_1_8V = 8'd139;
  localparam logic [7:0] V_3_3V = 8'd255;
  localparam logic [7:0] V_BATT = 8'd92;

  // Sleep-safe setpoints: only Shani, Rahu and Ketu are powered.
  localparam logic [71:0] VDD_RESET  = {V_BATT, V_0_6V, V_0_4V, 48'h0000_0000_0000};
  localparam logic [8:0]  GOOD_RESET = 9'b111_000_000;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RAMP   = 2'd1,
    SEQ_SETTLE = 2'd2
  } seq_state_t;

  // Move cur toward tgt by at most step; lands exactly on tgt, never wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] diff;
    logic [7:0] res;
    if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if (diff > {1'b0, step}) res = cur + step;
      else                     res = tgt;
    end else if (tgt < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff > {1'b0, step}) res = cur - step;
      else                     res = tgt;
    end else begin
      diff = 9'd0;
      res  = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/graha_seq_pick.sv
// Priority picker: falling domains win over rising ones. Among falling
// domains the lowest index (core) goes first; among rising domains the
// highest index (always-on) goes first.
module graha_seq_pick
  import graha_pkg::*;
(
  input  logic [8:0] pending,
  input  logic [8:0] falling,
  input  logic [8:0] rising,
  output logic [3:0] idx,
  output logic       valid
);

  logic [8:0] fall_m;
  logic [8:0] rise_m;

  // Choose one eligible domain; later loop iterations override earlier ones.
  always_comb begin
    fall_m = falling & pending;
    rise_m = rising & pending;
    idx    = IDX_NONE;
    valid  = 1'b0;
    if (|fall_m) begin
      valid = 1'b1;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
        idx = fall_m[i] ? 4'(i) : idx;
      end
    end else if (|rise_m) begin
      valid = 1'b1;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        idx = rise_m[i] ? 4'(i) : idx;
      end
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/graha_vdd_sequencer.sv
// Slews nine regulator setpoints toward their targets one domain at a time,
// with a bounded step rate, a settle interval and a per-domain timeout.
module graha_vdd_sequencer
  import graha_pkg::*;
#(
  parameter int STEP          = 4,
  parameter int RAMP_DIV      = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int TIMEOUT       = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seq_enable,
  input  logic [71:0] target_vdd,
  output logic [71:0] vdd_out,
  output logic [8:0]  domain_good,
  output logic        all_good,
  output logic        busy,
  output logic [3:0]  active_idx,
  output logic        fault,
  input  logic        fault_clr
);

  localparam logic [15:0] RAMP_LAST   = 16'(RAMP_DIV - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [7:0]  STEP_CODE   = 8'(STEP);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [15:0] step_cnt;
  logic [15:0] step_cnt_next;
  logic [15:0] settle_cnt;
  logic [15:0] settle_cnt_next;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_next;
  logic [71:0] vdd_next;
  logic [8:0]  good_next;
  logic [3:0]  idx_next;
  logic [3:0]  fault_idx;
  logic [3:0]  fault_idx_next;
  logic        fault_next;
  logic        fault_set;
  logic        busy_next;

  logic [8:0]  pending;
  logic [8:0]  falling;
  logic [8:0]  rising;
  logic [8:0]  eligible;
  logic [7:0]  act_cur;
  logic [7:0]  act_tgt;
  logic [7:0]  act_stepped;
  logic [3:0]  pick_idx;
  logic        pick_valid;
  logic        act_match;
  logic        step_hit;
  logic        settle_hit;
  logic        tmo_hit;

  // Classify every domain against its target; mux out the active domain.
  always_comb begin
    pending  = 9'd0;
    falling  = 9'd0;
    rising   = 9'd0;
    eligible = 9'd0;
    act_cur  = 8'd0;
    act_tgt  = 8'd0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      falling[i]  = target_vdd[8*i +: 8] < vdd_out[8*i +: 8];
      rising[i]   = target_vdd[8*i +: 8] > vdd_out[8*i +: 8];
      pending[i]  = falling[i] | rising[i];
      // A timed-out domain sits out selection until the fault is cleared.
      eligible[i] = pending[i] & ~(fault & (fault_idx == 4'(i)));
      act_cur     = (active_idx == 4'(i)) ? vdd_out[8*i +: 8]    : act_cur;
      act_tgt     = (active_idx == 4'(i)) ? target_vdd[8*i +: 8] : act_tgt;
    end
  end

  graha_seq_pick u_pick (
    .pending (eligible),
    .falling (falling),
    .rising  (rising),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  assign act_stepped = step_toward(act_cur, act_tgt, STEP_CODE);
  assign act_match   = (act_cur == act_tgt);
  assign step_hit    = (step_cnt == RAMP_LAST);
  assign settle_hit  = (settle_cnt == SETTLE_LAST);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign all_good    = &domain_good;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; a timeout always abandons the domain.
  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE: begin
        if (seq_enable && pick_valid) state_next = SEQ_RAMP;
        else                          state_next = SEQ_IDLE;
      end
      SEQ_RAMP: begin
        if (tmo_hit)                               state_next = SEQ_IDLE;
        else if (act_match)                        state_next = SEQ_SETTLE;
        else if (step_hit && act_stepped == act_tgt) state_next = SEQ_SETTLE;
        else                                       state_next = SEQ_RAMP;
      end
      SEQ_SETTLE: begin
        if (tmo_hit)         state_next = SEQ_IDLE;
        else if (!act_match) state_next = SEQ_RAMP;
        else if (settle_hit) state_next = SEQ_IDLE;
        else                 state_next = SEQ_SETTLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Datapath next values: counters, setpoint step, good flags, fault.
  always_comb begin
    vdd_next        = vdd_out;
    good_next       = domain_good & ~pending;
    idx_next        = active_idx;
    step_cnt_next   = step_cnt;
    settle_cnt_next = settle_cnt;
    tmo_cnt_next    = tmo_cnt;
    fault_set       = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (seq_enable && pick_valid) begin
          idx_next        = pick_idx;
          step_cnt_next   = 16'd0;
          settle_cnt_next = 16'd0;
          tmo_cnt_next    = 16'd0;
        end else begin
          idx_next = IDX_NONE;
        end
      end
      SEQ_RAMP: begin
        tmo_cnt_next    = tmo_cnt + 16'd1;
        settle_cnt_next = 16'd0;
        if (step_hit) begin
          step_cnt_next = 16'd0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            vdd_next[8*i +: 8] = (active_idx == 4'(i)) ? act_stepped : vdd_out[8*i +: 8];
          end
        end else begin
          step_cnt_next = step_cnt + 16'd1;
        end
        if (tmo_hit) begin
          fault_set = 1'b1;
          idx_next  = IDX_NONE;
        end else begin
          idx_next = active_idx;
        end
      end
      SEQ_SETTLE: begin
        tmo_cnt_next = tmo_cnt + 16'd1;
        if (tmo_hit) begin
          fault_set = 1'b1;
          idx_next  = IDX_NONE;
        end else if (!act_match) begin
          // Target moved while settling: ramp again, timeout keeps running.
          step_cnt_next   = 16'd0;
          settle_cnt_next = 16'd0;
        end else if (settle_hit) begin
          good_next = good_next | (9'd1 << active_idx);
          idx_next  = IDX_NONE;
        end else begin
          settle_cnt_next = settle_cnt + 16'd1;
        end
      end
      default: begin
        idx_next = IDX_NONE;
      end
    endcase

    // Clearing wins over a fault raised in the same cycle.
    if (fault_clr) begin
      fault_next     = 1'b0;
      fault_idx_next = IDX_NONE;
    end else if (fault_set) begin
      fault_next     = 1'b1;
      fault_idx_next = active_idx;
    end else begin
      fault_next     = fault;
      fault_idx_next = fault_idx;
    end

    busy_next = (state_next != SEQ_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vdd_out     <= VDD_RESET;
      domain_good <= GOOD_RESET;
      active_idx  <= IDX_NONE;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_idx   <= IDX_NONE;
      step_cnt    <= 16'd0;
      settle_cnt  <= 16'd0;
      tmo_cnt     <= 16'd0;
    end else begin
      vdd_out     <= vdd_next;
      domain_good <= good_next;
      active_idx  <= idx_next;
      busy        <= busy_next;
      fault       <= fault_next;
      fault_idx   <= fault_idx_next;
      step_cnt    <= step_cnt_next;
      settle_cnt  <= settle_cnt_next;
      tmo_cnt     <= tmo_cnt_next;
    end
  end

endmodule

// File: tb/tb_graha_vdd_sequencer.sv
// Bench for graha_vdd_sequencer: directed scenarios plus random retargeting,
// checked every cycle against a procedural reference model.
module tb_graha_vdd_sequencer;

  localparam int STEP          = 4;
  localparam int RAMP_DIV      = 4;
  localparam int SETTLE_CYCLES = 8;
  localparam int TIMEOUT       = 1023;
  localparam int T_TIMEOUT     = 20;
  localparam logic [71:0] SLEEP = {8'd92, 8'd46, 8'd31, 48'h0000_0000_0000};
  localparam logic [71:0] ACTIVE = {8'd255, 8'd62, 8'd46, 8'd77, 8'd54, 8'd139, 8'd93, 8'd77, 8'd77};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seq_enable, fault_clr;
  logic [71:0] target_vdd, vdd_out;
  logic [8:0]  domain_good;
  logic        all_good, busy, fault;
  logic [3:0]  active_idx;

  logic        t_enable, t_clr;
  logic [71:0] t_target, t_vdd_out;
  logic [8:0]  t_good;
  logic        t_all_good, t_busy, t_fault;
  logic [3:0]  t_idx;

  always #5 clk = ~clk;

  graha_vdd_sequencer #(.STEP(STEP), .RAMP_DIV(RAMP_DIV),
                        .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .seq_enable(seq_enable), .target_vdd(target_vdd),
    .vdd_out(vdd_out), .domain_good(domain_good), .all_good(all_good), .busy(busy),
    .active_idx(active_idx), .fault(fault), .fault_clr(fault_clr));

  graha_vdd_sequencer #(.STEP(STEP), .RAMP_DIV(RAMP_DIV),
                        .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(T_TIMEOUT)) dut_t (
    .clk(clk), .rst_n(rst_n), .seq_enable(t_enable), .target_vdd(t_target),
    .vdd_out(t_vdd_out), .domain_good(t_good), .all_good(t_all_good), .busy(t_busy),
    .active_idx(t_idx), .fault(t_fault), .fault_clr(t_clr));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_vdd [9];
  logic [8:0] m_good;
  logic       m_fault;
  int         m_fault_dom;
  logic [3:0] m_idx;
  logic       m_busy;
  logic       m_clr_now;
  bit         chk_on = 0;

  function automatic logic [7:0] m_tgt(input int d);
    return target_vdd[8*d +: 8];
  endfunction

  function automatic logic [71:0] pack_vdd();
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[8*i +: 8] = m_vdd[i];
    return r;
  endfunction

  function automatic logic [7:0] move_toward(input logic [7:0] cur, input logic [7:0] tgt);
    int c = int'(cur);
    int g = int'(tgt);
    if (g > c) return (g - c > STEP) ? 8'(c + STEP) : tgt;
    if (g < c) return (c - g > STEP) ? 8'(c - STEP) : tgt;
    return cur;
  endfunction

  // Falling rails go first, lowest index; then rising rails, highest index.
  function automatic int m_pick();
    int d = -1;
    for (int i = 0; i < 9; i++)
      if (d < 0 && !(m_fault && m_fault_dom == i) && m_tgt(i) < m_vdd[i]) d = i;
    for (int i = 8; i >= 0; i--)
      if (d < 0 && !(m_fault && m_fault_dom == i) && m_tgt(i) > m_vdd[i]) d = i;
    return d;
  endfunction

  task automatic m_edge();
    @(posedge clk);
    m_clr_now = fault_clr;
    for (int i = 0; i < 9; i++)
      if (m_tgt(i) != m_vdd[i]) m_good[i] = 1'b0;
  endtask

  task automatic m_close();
    if (m_clr_now) begin
      m_fault = 1'b0;
      m_fault_dom = -1;
    end
  endtask

  task automatic m_service(input int d);
    bit ramping = 1;
    bit done = 0;
    bit abort;
    int cnt = 0;
    int t = 0;
    logic [7:0] tg;
    while (!done) begin
      m_edge();
      t++;
      tg = m_tgt(d);
      abort = (t == TIMEOUT);
      if (ramping) begin
        if (m_vdd[d] == tg) begin
          ramping = 0;
          cnt = 0;
        end else begin
          cnt++;
          if (cnt == RAMP_DIV) begin
            cnt = 0;
            m_vdd[d] = move_toward(m_vdd[d], tg);
            if (m_vdd[d] == tg) ramping = 0;
          end
        end
      end else if (!abort) begin
        if (m_vdd[d] != tg) begin
          ramping = 1;
          cnt = 0;
        end else begin
          cnt++;
          if (cnt == SETTLE_CYCLES) begin
            m_good[d] = 1'b1;
            done = 1;
          end
        end
      end
      if (abort) begin
        m_fault = 1'b1;
        m_fault_dom = d;
        done = 1;
      end
      if (done) begin
        m_idx = 4'hF;
        m_busy = 1'b0;
      end
      m_close();
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) m_vdd[i] = SLEEP[8*i +: 8];
    m_good = 9'h1C0;
    m_fault = 1'b0;
    m_fault_dom = -1;
    m_idx = 4'hF;
    m_busy = 1'b0;
    wait (rst_n === 1'b1);
    forever begin
      int d;
      m_edge();
      d = seq_enable ? m_pick() : -1;
      if (d >= 0) begin
        m_idx = 4'(d);
        m_busy = 1'b1;
        m_close();
        m_service(d);
      end else begin
        m_idx = 4'hF;
        m_close();
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("vdd_out", vdd_out, pack_vdd());
      check_eq("domain_good", 72'(domain_good), 72'(m_good));
      check_eq("all_good", 72'(all_good), 72'(&m_good));
      check_eq("busy", 72'(busy), 72'(m_busy));
      check_eq("active_idx", 72'(active_idx), 72'(m_idx));
      check_eq("fault", 72'(fault), 72'(m_fault));
    end
  end

  // Record the service order as seen on active_idx.
  int order_q[$];
  int exp_q[$];
  logic [3:0] last_idx = 4'hF;
  always @(negedge clk) begin
    if (active_idx != last_idx && active_idx != 4'hF) order_q.push_back(int'(active_idx));
    last_idx = active_idx;
  end

  task automatic check_order(input string tag);
    check_eq({tag, "_len"}, 72'(order_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < order_q.size()) check_eq(tag, 72'(order_q[i]), 72'(exp_q[i]));
  endtask

  task automatic apply_and_wait(input logic [71:0] vec, input int budget);
    int cyc = 0;
    order_q.delete();
    target_vdd = vec;
    repeat (2) begin @(negedge clk); cyc++; end
    while (!(all_good && !busy) && cyc < budget) begin @(negedge clk); cyc++; end
    check_eq("drain_in_budget", 72'(cyc < budget), 72'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [71:0] vec;
    logic [71:0] tv;
    int cyc;
    seq_enable = 1'b1;
    fault_clr  = 1'b0;
    target_vdd = SLEEP;
    t_enable   = 1'b1;
    t_clr      = 1'b0;
    t_target   = SLEEP;
    repeat (3) @(negedge clk);
    check_eq("rst_vdd", vdd_out, SLEEP);
    check_eq("rst_good", 72'(domain_good), 72'h1C0);
    check_eq("rst_busy", 72'(busy), 72'd0);
    check_eq("rst_idx", 72'(active_idx), 72'hF);
    check_eq("rst_fault", 72'(fault), 72'd0);
    check_eq("rst_all_good", 72'(all_good), 72'd0);
    rst_n = 1'b1;
    chk_on = 1;

    // Targets equal to the reset setpoints: nothing to do.
    repeat (20) @(negedge clk);
    check_eq("idle_busy", 72'(busy), 72'd0);
    check_eq("idle_good", 72'(domain_good), 72'h1C0);
    check_eq("idle_vdd", vdd_out, SLEEP);

    // Surya 0 -> 62: 16 steps of 4 clocks, then 8 settle clocks.
    vec = SLEEP;
    vec[7:0] = 8'd62;
    target_vdd = vec;
    cyc = 0;
    while (!domain_good[0] && cyc < 300) begin @(negedge clk); cyc++; end
    check_eq("surya_latency", 72'(cyc), 72'd73);
    check_eq("surya_vdd", 72'(vdd_out[7:0]), 72'd62);

    // Power-up: rising rails, always-on first.
    apply_and_wait(ACTIVE, 3000);
    exp_q.delete();
    for (int i = 8; i >= 0; i--) exp_q.push_back(i);
    check_order("order_up");

    // Power-down: falling rails, core first.
    apply_and_wait(SLEEP, 3000);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(i);
    check_order("order_down");

    // Mixed: Surya falls and Guru rises in the same cycle.
    vec = SLEEP;
    vec[7:0] = 8'd62;
    apply_and_wait(vec, 500);
    vec[7:0] = 8'd0;
    vec[39:32] = 8'd93;
    apply_and_wait(vec, 1000);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(4);
    check_order("order_mixed");

    // Reverse Surya mid-ramp at code 40.
    vec[7:0] = 8'd62;
    target_vdd = vec;
    cyc = 0;
    while (vdd_out[7:0] != 8'd40 && cyc < 300) begin @(negedge clk); cyc++; end
    check_eq("reach_40", 72'(cyc < 300), 72'd1);
    vec[7:0] = 8'd20;
    apply_and_wait(vec, 500);
    check_eq("reverse_vdd", 72'(vdd_out[7:0]), 72'd20);
    check_eq("reverse_fault", 72'(fault), 72'd0);

    // Random retargeting with enable toggling and occasional clears.
    for (int r = 0; r < 40; r++) begin
      int n;
      vec = target_vdd;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        int d;
        d = $urandom_range(0, 8);
        vec[8*d +: 8] = 8'($urandom_range(0, 255));
      end
      target_vdd = vec;
      seq_enable = ($urandom_range(0, 3) != 0);
      fault_clr  = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      fault_clr = 1'b0;
      repeat ($urandom_range(5, 150)) @(negedge clk);
    end
    seq_enable = 1'b1;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    cyc = 0;
    while (!(vdd_out == target_vdd && !busy) && cyc < 8000) begin @(negedge clk); cyc++; end
    check_eq("random_drain", vdd_out, target_vdd);

    // Timeout instance: Shukra 0 -> 255 with a 20-clock budget.
    tv = SLEEP;
    tv[47:40] = 8'd255;
    t_target = tv;
    cyc = 0;
    while (!t_fault && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq("tmo_cycle", 72'(cyc), 72'd21);
    check_eq("tmo_vdd5", 72'(t_vdd_out[47:40]), 72'd20);
    check_eq("tmo_good5", 72'(t_good[5]), 72'd0);
    check_eq("tmo_busy", 72'(t_busy), 72'd0);
    check_eq("tmo_idx", 72'(t_idx), 72'hF);
    repeat (5) @(negedge clk);
    check_eq("tmo_skip_idx", 72'(t_idx), 72'hF);
    check_eq("tmo_hold_vdd5", 72'(t_vdd_out[47:40]), 72'd20);
    check_eq("tmo_sticky", 72'(t_fault), 72'd1);
    t_clr = 1'b1;
    @(negedge clk);
    t_clr = 1'b0;
    check_eq("tmo_cleared", 72'(t_fault), 72'd0);
    @(negedge clk);
    check_eq("tmo_reselect_idx", 72'(t_idx), 72'd5);
    check_eq("tmo_reselect_busy", 72'(t_busy), 72'd1);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
